// File: rtl/snake_body_collision_scanner.sv
// Snake body store with a sequential one-compare-per-clock collision scanner.
// Optional macro SNAKE_SCAN_SKIP_HEAD_EN excludes the newest segment from each scan.
module snake_body_collision_scanner #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pos,
    input  logic             pop,
    input  logic             query_valid,
    input  logic [WIDTH-1:0] query_pos,
    output logic             query_ready,
    output logic             result_valid,
    output logic             hit,
    output logic [IDXW-1:0]  hit_index,
    output logic [IDXW:0]    count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDXW:0] FULL_COUNT = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0] ONE        = (IDXW+1)'(1);

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDXW-1:0]  rd_ptr, wr_ptr, idx, rd_addr, found_idx;
    logic [IDXW:0]    n, snap_n;
    logic [WIDTH-1:0] qpos;
    logic             found, idle, do_push, do_pop, match, last;

    assign query_ready = idle;
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);

    always_comb begin
        idle       = (state == IDLE);
        do_pop     = pop && idle && !empty;
        // A full buffer still accepts a push when a pop frees a slot in the same cycle.
        do_push    = push && idle && (!full || do_pop);
        rd_addr    = rd_ptr + idx;
        match      = (mem[rd_addr] == qpos);
        last       = ({1'b0, idx} == (n - ONE));
`ifdef SNAKE_SCAN_SKIP_HEAD_EN
        snap_n     = (count == '0) ? '0 : (count - ONE);
`else
        snap_n     = count;
`endif
        state_next = state;
        case (state)
            IDLE: if (query_valid) state_next = (snap_n != '0) ? SCAN : DONE;
            SCAN: if (match || last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_pos;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            hit_index    <= '0;
            found        <= 1'b0;
            found_idx    <= '0;
            idx          <= '0;
            n            <= '0;
            qpos         <= '0;
        end else begin
            result_valid <= (state == DONE);
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            // Scan result is published together with the result_valid pulse.
            case (state)
                IDLE: if (query_valid) begin
                    qpos      <= query_pos;
                    n         <= snap_n;
                    idx       <= '0;
                    found     <= 1'b0;
                    found_idx <= '0;
                end
                SCAN: begin
                    if (match) begin
                        found     <= 1'b1;
                        found_idx <= idx;
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    hit       <= found;
                    hit_index <= found_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_collision_scanner.sv
// Directed self-checking bench for snake_body_collision_scanner, assertion based.
module tb_snake_body_collision_scanner;

`ifdef SNAKE_SCAN_SKIP_HEAD_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [19:0] push_pos = '0;
    logic        pop = 1'b0;
    logic        query_valid = 1'b0;
    logic [19:0] query_pos = '0;
    logic        query_ready, result_valid, hit, full, empty;
    logic [4:0]  hit_index;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    snake_body_collision_scanner #(.WIDTH(20), .DEPTH(32), .IDXW(5)) dut (
        .clk(clk), .rst(rst), .push(push), .push_pos(push_pos), .pop(pop),
        .query_valid(query_valid), .query_pos(query_pos), .query_ready(query_ready),
        .result_valid(result_valid), .hit(hit), .hit_index(hit_index),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushValue(input logic [19:0] v);
        push = 1'b1;
        push_pos = v;
        tick();
        push = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int missEdges(input int c);
        int nn;
        nn = c - SKIP;
        return (nn <= 0) ? 1 : nn + 1;
    endfunction

    // Accept a query at edge 0, then count edges until result_valid is seen.
    task automatic applyStimulus(input string tag, input logic [19:0] v, input int exp_edges,
                                 input logic exp_hit, input logic [4:0] exp_idx, input logic push_mid);
        int edges;
        bit seen;
        query_valid = 1'b1;
        query_pos = v;
        tick();
        query_valid = 1'b0;
        checkOutput({tag, "_busy"}, 32'(query_ready), 32'd0);
        if (push_mid) begin
            push = 1'b1;
            push_pos = 20'h12345;
        end
        edges = 0;
        seen = 0;
        while (!seen && edges < 100) begin
            tick();
            edges++;
            if (result_valid) seen = 1;
        end
        push = 1'b0;
        checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
        checkOutput({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        checkOutput({tag, "_index"}, 32'(hit_index), 32'(exp_idx));
        tick();
        checkOutput({tag, "_pulse_end"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        tick();
        doReset();
        checkOutput("rst_ready", 32'(query_ready), 32'd1);
        checkOutput("rst_rv", 32'(result_valid), 32'd0);
        checkOutput("rst_hit", 32'(hit), 32'd0);
        checkOutput("rst_idx", 32'(hit_index), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);

        applyStimulus("empty_q", 20'h00000, 1, 1'b0, 5'd0, 1'b0);
        checkOutput("empty_q_count", 32'(count), 32'd0);
        checkOutput("empty_q_empty", 32'(empty), 32'd1);

        pushValue(20'h01010);
        pushValue(20'h02020);
        pushValue(20'h03030);
        checkOutput("three_count", 32'(count), 32'd3);
        applyStimulus("hit1", 20'h02020, 3, 1'b1, 5'd1, 1'b0);
        applyStimulus("miss3", 20'h0FFFF, missEdges(3), 1'b0, 5'd0, 1'b1);
        checkOutput("frozen_count", 32'(count), 32'd3);

        query_valid = 1'b1;
        query_pos = 20'h03030;
        tick();
        query_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_rv", 32'(result_valid), 32'd0);
        checkOutput("abort_count", 32'(count), 32'd0);
        checkOutput("abort_ready", 32'(query_ready), 32'd1);
        tick();
        tick();
        checkOutput("abort_no_pulse", 32'(result_valid), 32'd0);

        pop = 1'b1;
        tick();
        pop = 1'b0;
        checkOutput("pop_empty_count", 32'(count), 32'd0);
        pop = 1'b1;
        pushValue(20'h07070);
        pop = 1'b0;
        checkOutput("pushpop_empty_count", 32'(count), 32'd1);
        if (SKIP != 0) applyStimulus("single", 20'h07070, 1, 1'b0, 5'd0, 1'b0);
        else           applyStimulus("single", 20'h07070, 2, 1'b1, 5'd0, 1'b0);

        doReset();
        pushValue(20'h05050);
        pushValue(20'h05050);
        applyStimulus("dup", 20'h05050, 2, 1'b1, 5'd0, 1'b0);

        doReset();
        for (int i = 0; i < 32; i++) pushValue(20'h40000 + 20'(i));
        checkOutput("fill_count", 32'(count), 32'd32);
        checkOutput("fill_full", 32'(full), 32'd1);
        pushValue(20'hBBBBB);
        checkOutput("overflow_count", 32'(count), 32'd32);
        applyStimulus("overflow_absent", 20'hBBBBB, missEdges(32), 1'b0, 5'd0, 1'b0);
        pop = 1'b1;
        pushValue(20'hAAAAA);
        pop = 1'b0;
        checkOutput("move_count", 32'(count), 32'd32);
        checkOutput("move_full", 32'(full), 32'd1);
        if (SKIP != 0) applyStimulus("wrap_head", 20'hAAAAA, missEdges(32), 1'b0, 5'd0, 1'b0);
        else           applyStimulus("wrap_head", 20'hAAAAA, 33, 1'b1, 5'd31, 1'b0);
        applyStimulus("popped_tail", 20'h40000, missEdges(32), 1'b0, 5'd0, 1'b0);
        applyStimulus("new_tail", 20'h40001, 2, 1'b1, 5'd0, 1'b0);
        applyStimulus("mid_body", 20'h40010, 17, 1'b1, 5'd15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_body_collision_scanner.md
Name: snake_body_collision_scanner

Overview:
- Parametrised successor to the single-pair 20-bit equality comparator.
- Holds the snake body as a circular buffer of packed {x,y} positions, DEPTH entries of WIDTH bits.
- On request, sequentially compares one query position against every stored segment, one compare per clock.
- Reports hit or miss and the matching segment index. Used by the game controller for self-collision and food-on-body checks.

Parameters:
- WIDTH, 20, bits per packed position; the compare is an equality test across all WIDTH bits.
- DEPTH, 32, maximum stored segments; must be a power of two and at least 2.
- IDXW, 5, index width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  append push_pos as the new head; accepted only when query_ready=1.
- push_pos  in  WIDTH  head position to append.
- pop  in  1  drop the oldest segment (the tail); accepted only when query_ready=1.
- query_valid  in  1  request a scan of query_pos.
- query_pos  in  WIDTH  position to test.
- query_ready  out  1  high in IDLE only.
- result_valid  out  1  one-cycle pulse when a scan completes.
- hit  out  1  scan found a match; held until the next result.
- hit_index  out  IDXW  age of the matching entry (0 = tail); 0 on a miss.
- count  out  IDXW+1  number of stored segments, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset values: rd_ptr=0, wr_ptr=0, count=0, state=IDLE, query_ready=1, result_valid=0, hit=0, hit_index=0, full=0, empty=1. Buffer contents are don't-care.
- Storage: write at wr_ptr, read base at rd_ptr. Pointers are IDXW bits and wrap naturally from DEPTH-1 to 0.
- Push alone:
  - not full: write, wr_ptr+1, count+1.
  - full: ignored, nothing changes.
- Pop alone:
  - not empty: rd_ptr+1, count-1.
  - empty: ignored.
- Push and pop in the same cycle:
  - non-empty (including full): both take effect, count unchanged. This is the snake moving.
  - empty: the push takes effect and the pop is ignored, so count=1.
- push and pop are ignored whenever state is not IDLE. The buffer is frozen during a scan.
- FSM IDLE:
  - query_ready=1.
  - On query_valid: latch query_pos, snapshot count into n, set idx=0.
  - Go to SCAN if n>0, otherwise go to DONE with hit=0.
  - A push/pop in the same cycle as query acceptance also takes effect; the snapshot n uses the pre-update count.
- FSM SCAN:
  - Compare buf[(rd_ptr+idx) mod DEPTH] with the latched query position.
  - On equality: hit=1, hit_index=idx, go to DONE.
  - Else if idx==n-1: hit=0, hit_index=0, go to DONE.
  - Else idx+1.
- FSM DONE: result_valid=1 for exactly one cycle, then return to IDLE (query_ready=1 on the next cycle).
- Latency, with acceptance at edge 0:
  - match at index k: result_valid is high in the cycle after edge k+2.
  - miss over n entries: result_valid follows edge n+1.
  - empty buffer: result_valid follows edge 1.
- The first match wins, i.e. the lowest index (oldest segment).
- rst during SCAN or DONE: return to IDLE immediately, no result_valid pulse, buffer emptied.
- query_valid while query_ready=0 is ignored. The requester must hold query_valid until it sees query_ready.

Optional Feature:
- Macro: SNAKE_SCAN_SKIP_HEAD_EN.
- Defined:
  - the newest entry (index count-1) is excluded from the scan, so n = count-1 at snapshot.
  - count ≤ 1 yields an immediate miss via DONE.
  - Purpose: lets the head be checked against its own body.
- Undefined: all count entries are scanned, as described above.

Test Plan:
- Reset, then query 20'h00000 -> result_valid follows edge 1 with hit=0; count=0, empty=1.
- Push 20'h01010, 20'h02020, 20'h03030, then query 20'h02020 -> hit=1, hit_index=1, result_valid follows edge 3.
- Push 32 distinct values; full=1; a 33rd push is ignored. Simultaneous push 20'hAAAAA and pop -> count stays 32, rd_ptr and wr_ptr wrap. Query 20'hAAAAA -> hit_index=31.
- Hold 3 entries and query a missing value -> hit=0 after edge 4. push asserted mid-scan is ignored: count stays 3.
- Assert rst two cycles into a scan -> no result_valid pulse; count=0 and query_ready=1 on the next cycle.
- With SNAKE_SCAN_SKIP_HEAD_EN: push 20'h05050 twice, query 20'h05050 -> hit=1, hit_index=0. With one entry only -> hit=0.
